// File: rtl/alu_mc_if.sv
// Request/response bundle between the control unit and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUctrl;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] ALUres;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, ALUctrl, op1, op2,
    input  ALUres, hi, zero, busy, done, div_by_zero
  );

  modport slave (
    input  start, ALUctrl, op1, op2,
    output ALUres, hi, zero, busy, done, div_by_zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative unsigned
// shift-add multiply and restoring divide, start/busy/done handshake.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input logic   clk,
  input logic   reset,
  alu_mc_if.slave bus
);
  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpAndn = 4'b0100;
  localparam logic [3:0] OpOrn  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;
  localparam logic [3:0] OpMulu = 4'b1100;
  localparam logic [3:0] OpDivu = 4'b1101;

  typedef enum logic [0:0] {StIdle, StCalc} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  // acc: upper product half (MULU) or partial remainder (DIVU)
  logic [WIDTH:0]    acc_q, acc_d;
  // lo: multiplier shifting into the low product half (MULU) or
  // dividend shifting out while quotient bits shift in (DIVU)
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  sc_res;
  logic [ShW-1:0]    shamt;
  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic              div_ge;
  logic [WIDTH:0]    step_acc;
  logic [WIDTH-1:0]  step_lo;
  logic [WIDTH-1:0]  fin_res;
  logic [WIDTH-1:0]  fin_hi;

  assign shamt = bus.op2[ShW-1:0];

  // Single-cycle result computed straight from the live operands
  always_comb begin
    sc_res = '0;
    case (bus.ALUctrl)
      OpAnd:   sc_res = bus.op1 & bus.op2;
      OpOr:    sc_res = bus.op1 | bus.op2;
      OpAdd:   sc_res = bus.op1 + bus.op2;
      OpAndn:  sc_res = bus.op1 & ~bus.op2;
      OpOrn:   sc_res = bus.op1 | ~bus.op2;
      OpSub:   sc_res = bus.op1 - bus.op2;
      OpSlt:   sc_res = {{(WIDTH - 1){1'b0}}, (bus.op1 < bus.op2)};
      OpSll:   sc_res = bus.op1 << shamt;
      OpSrl:   sc_res = bus.op1 >> shamt;
      OpSra:   sc_res = $signed(bus.op1) >>> shamt;
      default: sc_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    if (div_q) begin
      step_acc = div_ge ? (div_shift - {1'b0, b_q}) : div_shift;
      step_lo  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_acc = {1'b0, mul_sum[WIDTH:1]};
      step_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    // Divide by zero reports all-ones quotient and the dividend as remainder
    if (div_q && (b_q == '0)) begin
      fin_res = '1;
      fin_hi  = a_q;
    end else begin
      fin_res = step_lo;
      fin_hi  = step_acc[WIDTH-1:0];
    end
  end

  // Next-state and result-register update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dbz_d = 1'b0;
          a_d   = bus.op1;
          b_d   = bus.op2;
          if ((bus.ALUctrl == OpMulu) || (bus.ALUctrl == OpDivu)) begin
            div_d   = (bus.ALUctrl == OpDivu);
            acc_d   = '0;
            lo_d    = (bus.ALUctrl == OpDivu) ? bus.op1 : bus.op2;
            cnt_d   = CntW'(WIDTH);
            state_d = StCalc;
          end else begin
            res_d  = sc_res;
            hi_d   = '0;
            zero_d = (sc_res == '0);
            done_d = 1'b1;
          end
        end
      end
      StCalc: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          res_d   = fin_res;
          hi_d    = fin_hi;
          zero_d  = (fin_res == '0);
          dbz_d   = div_q && (b_q == '0);
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset wins over a simultaneous start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ALUres      = res_q;
  assign bus.hi          = hi_q;
  assign bus.zero        = zero_q;
  assign bus.busy        = (state_q == StCalc);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) b32 ();
  alu_mc_if #(.WIDTH(8))  b8 ();

  alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
  alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  int cyc;
  int dones;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request; returns 1 time unit after the accepting edge
  task automatic go32(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    b32.start = 1'b1; b32.ALUctrl = c; b32.op1 = a; b32.op2 = b;
    @(posedge clk); #1;
    b32.start = 1'b0;
  endtask

  task automatic go8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    b8.start = 1'b1; b8.ALUctrl = c; b8.op1 = a; b8.op2 = b;
    @(posedge clk); #1;
    b8.start = 1'b0;
  endtask

  task automatic wait32(output int n);
    n = 0;
    while (b32.done !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (b8.done !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
  endtask

  // busy and done must never coincide
  always @(negedge clk) begin
    if ((b32.busy && b32.done) || (b8.busy && b8.done)) overlap++;
  end

  initial begin
    reset = 1'b1;
    b32.start = 1'b0; b32.ALUctrl = '0; b32.op1 = '0; b32.op2 = '0;
    b8.start  = 1'b0; b8.ALUctrl  = '0; b8.op1  = '0; b8.op2  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res",  b32.ALUres, 0);
    check("rst_hi",   b32.hi, 0);
    check("rst_zero", b32.zero, 0);
    check("rst_busy", b32.busy, 0);
    check("rst_done", b32.done, 0);
    check("rst_dbz",  b32.div_by_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ADD then SUB back to back
    b32.start = 1'b1; b32.ALUctrl = 4'b0010; b32.op1 = 5; b32.op2 = 7;
    @(posedge clk); #1;
    check("add_res",  b32.ALUres, 12);
    check("add_zero", b32.zero, 0);
    check("add_done", b32.done, 1);
    check("add_busy", b32.busy, 0);
    b32.ALUctrl = 4'b0110; b32.op1 = 9; b32.op2 = 9;
    @(posedge clk); #1;
    b32.start = 1'b0;
    check("sub_res",  b32.ALUres, 0);
    check("sub_zero", b32.zero, 1);
    check("sub_done", b32.done, 1);
    @(posedge clk); #1;
    check("done_drop", b32.done, 0);
    check("hold_zero", b32.zero, 1);

    go32(4'b1010, 32'h8000_0000, 4);
    check("sra", b32.ALUres, 64'hF800_0000);
    go32(4'b1001, 32'h8000_0000, 4);
    check("srl", b32.ALUres, 64'h0800_0000);
    go32(4'b1000, 1, 35);
    check("sll", b32.ALUres, 8);
    go32(4'b0111, 3, 32'hFFFF_FFFF);
    check("slt", b32.ALUres, 1);
    go32(4'b0100, 32'h0000_F0F0, 32'h0000_FF00);
    check("andn", b32.ALUres, 64'h0000_00F0);
    go32(4'b0011, 32'h1234, 32'h5678);
    check("undef_res",  b32.ALUres, 0);
    check("undef_zero", b32.zero, 1);

    // MULU
    go32(4'b1100, 32'hFFFF_FFFF, 2);
    check("mul_busy", b32.busy, 1);
    wait32(cyc);
    check("mul_lat",  cyc, 32);
    check("mul_lo",   b32.ALUres, 64'hFFFF_FFFE);
    check("mul_hi",   b32.hi, 1);
    check("mul_zero", b32.zero, 0);
    check("mul_nbsy", b32.busy, 0);
    @(posedge clk); #1;
    check("mul_pulse", b32.done, 0);
    check("mul_hold",  b32.hi, 1);

    // DIVU
    go32(4'b1101, 100, 7);
    wait32(cyc);
    check("div_lat", cyc, 32);
    check("div_q",   b32.ALUres, 14);
    check("div_r",   b32.hi, 2);
    check("div_dbz", b32.div_by_zero, 0);
    go32(4'b1101, 100, 0);
    wait32(cyc);
    check("dz_lat", cyc, 32);
    check("dz_q",   b32.ALUres, 64'hFFFF_FFFF);
    check("dz_r",   b32.hi, 100);
    check("dz_flag", b32.div_by_zero, 1);
    go32(4'b0010, 1, 1);
    check("dz_clear", b32.div_by_zero, 0);
    check("add2", b32.ALUres, 2);

    // start during MULU is ignored, operand changes have no effect
    go32(4'b1100, 3, 5);
    for (int i = 0; i < 4; i++) begin
      b32.start = 1'b1; b32.ALUctrl = 4'b0010; b32.op1 = 1; b32.op2 = 1;
      @(posedge clk); #1;
    end
    b32.start = 1'b0;
    wait32(cyc);
    check("ign_lat", cyc + 4, 32);
    check("ign_lo",  b32.ALUres, 15);
    check("ign_hi",  b32.hi, 0);

    // reset mid-MULU
    go32(4'b1100, 7, 9);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("ab_res",  b32.ALUres, 0);
    check("ab_hi",   b32.hi, 0);
    check("ab_zero", b32.zero, 0);
    check("ab_busy", b32.busy, 0);
    check("ab_done", b32.done, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (b32.done) dones++;
    end
    check("ab_nodone", dones, 0);
    go32(4'b0010, 2, 3);
    check("post_rst", b32.ALUres, 5);
    check("post_done", b32.done, 1);

    // WIDTH=8 instance
    go8(4'b1100, 8'hFF, 8'hFF);
    wait8(cyc);
    check("w8_lat", cyc, 8);
    check("w8_lo",  b8.ALUres, 8'h01);
    check("w8_hi",  b8.hi, 8'hFE);
    go8(4'b0010, 8'hFF, 8'h01);
    check("w8_add",  b8.ALUres, 0);
    check("w8_zero", b8.zero, 1);
    go8(4'b1101, 8'd200, 8'd9);
    wait8(cyc);
    check("w8_dq", b8.ALUres, 22);
    check("w8_dr", b8.hi, 2);

    check("busy_done_excl", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
